// File: rtl/gpu_regfile_banked_pkg.sv
// Shared sizing, types and FSM encoding for the banked GPU register file.
package gpu_regfile_banked_pkg;
  localparam int RF_NUM_BANKS       = 4;
  localparam int RF_PHYS_ADDR_WIDTH = 10;
  localparam int RF_DATA_WIDTH      = 32;
  localparam int NUM_READ_PORTS_RF  = 3;
  localparam int NUM_WRITE_PORTS_RF = 5;

  typedef logic [RF_PHYS_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0]      rf_data_t;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/gpu_regfile_banked_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, then
// moves ptr past the winner when advance is high.
module gpu_regfile_banked_rr_arbiter
  import gpu_regfile_banked_pkg::*;
#(
  parameter int N = NUM_READ_PORTS_RF,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/gpu_regfile_banked.sv
// Banked multi-port register file: per-bank round-robin read/write arbitration,
// 1-cycle read latency with write-first bypass, and a zeroing sweep after reset.
//   state   | meaning
//   RF_INIT | zero one row in every bank per cycle, all readies held low
//   RF_RUN  | normal arbitrated reads and writes until reset
module gpu_regfile_banked
  import gpu_regfile_banked_pkg::*;
#(
  parameter int DATA_WIDTH      = RF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH  = RF_PHYS_ADDR_WIDTH,
  parameter int NUM_BANKS       = RF_NUM_BANKS,
  parameter int NUM_READ_PORTS  = NUM_READ_PORTS_RF,
  parameter int NUM_WRITE_PORTS = NUM_WRITE_PORTS_RF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_READ_PORTS-1:0]             rd_req_valid,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]  rd_req_addr,
  output logic [NUM_READ_PORTS-1:0]             rd_req_ready,
  output logic [NUM_READ_PORTS-1:0]             rd_rsp_valid,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_rsp_data,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_valid,
  input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WRITE_PORTS-1:0]            wr_ready,
  output logic                                  init_done
);
  localparam int BW    = $clog2(NUM_BANKS);
  localparam int ROW_W = REG_ADDR_WIDTH - BW;
  localparam int ROWS  = 2 ** ROW_W;
  localparam int RD_PW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
  localparam int WR_PW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  rf_state_e        state, state_nxt;
  logic [ROW_W-1:0] init_row, init_row_nxt;
  logic             run;

  logic [BW-1:0]    rd_bank [NUM_READ_PORTS];
  logic [ROW_W-1:0] rd_row  [NUM_READ_PORTS];
  logic [BW-1:0]    wr_bank [NUM_WRITE_PORTS];
  logic [ROW_W-1:0] wr_row  [NUM_WRITE_PORTS];

  logic [NUM_READ_PORTS-1:0]  rd_req_b [NUM_BANKS];
  logic [NUM_READ_PORTS-1:0]  rd_gnt_b [NUM_BANKS];
  logic [NUM_WRITE_PORTS-1:0] wr_req_b [NUM_BANKS];
  logic [NUM_WRITE_PORTS-1:0] wr_gnt_b [NUM_BANKS];
  logic [RD_PW-1:0]           rd_ptr   [NUM_BANKS];
  logic [WR_PW-1:0]           wr_ptr   [NUM_BANKS];

  logic                  bank_rd_en   [NUM_BANKS];
  logic                  bank_wr_en   [NUM_BANKS];
  logic [ROW_W-1:0]      bank_rd_row  [NUM_BANKS];
  logic [ROW_W-1:0]      bank_wr_row  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wr_data [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] mem          [NUM_BANKS][ROWS];

  logic [NUM_READ_PORTS-1:0] rsp_valid;
  logic [BW-1:0]             rsp_bank [NUM_READ_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RF_INIT;
      init_row <= '0;
    end else begin
      state    <= state_nxt;
      init_row <= init_row_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_row_nxt = init_row;
    case (state)
      RF_INIT: begin
        init_row_nxt = init_row + 1'b1;
        if (init_row == '1) state_nxt = RF_RUN;
      end
      RF_RUN:  state_nxt = RF_RUN;
      default: state_nxt = RF_INIT;
    endcase
  end

  // Gating with rst keeps a reset cycle from accepting anything.
  assign run       = (state == RF_RUN) && !rst;
  assign init_done = (state == RF_RUN);

  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_bank[p] = rd_req_addr[p*REG_ADDR_WIDTH +: BW];
      rd_row[p]  = rd_req_addr[p*REG_ADDR_WIDTH+BW +: ROW_W];
    end
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      wr_bank[p] = wr_addr[p*REG_ADDR_WIDTH +: BW];
      wr_row[p]  = wr_addr[p*REG_ADDR_WIDTH+BW +: ROW_W];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_READ_PORTS; p++)
        rd_req_b[b][p] = run && rd_req_valid[p] && (rd_bank[p] == BW'(b));
      for (int p = 0; p < NUM_WRITE_PORTS; p++)
        wr_req_b[b][p] = run && wr_valid[p] && (wr_bank[p] == BW'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    gpu_regfile_banked_rr_arbiter #(.N(NUM_READ_PORTS)) u_rd_arb (
      .clk(clk), .rst(rst), .req(rd_req_b[b]), .advance(run),
      .grant(rd_gnt_b[b]), .ptr(rd_ptr[b])
    );
    gpu_regfile_banked_rr_arbiter #(.N(NUM_WRITE_PORTS)) u_wr_arb (
      .clk(clk), .rst(rst), .req(wr_req_b[b]), .advance(run),
      .grant(wr_gnt_b[b]), .ptr(wr_ptr[b])
    );

    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
      (int'(rd_ptr[b]) < NUM_READ_PORTS) && (int'(wr_ptr[b]) < NUM_WRITE_PORTS));
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_rd_en[b]   = |rd_gnt_b[b];
      bank_wr_en[b]   = |wr_gnt_b[b];
      bank_rd_row[b]  = '0;
      bank_wr_row[b]  = '0;
      bank_wr_data[b] = '0;
      for (int p = 0; p < NUM_READ_PORTS; p++)
        if (rd_gnt_b[b][p]) bank_rd_row[b] = rd_row[p];
      for (int p = 0; p < NUM_WRITE_PORTS; p++)
        if (wr_gnt_b[b][p]) begin
          bank_wr_row[b]  = wr_row[p];
          bank_wr_data[b] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    for (int p = 0; p < NUM_READ_PORTS; p++)
      rd_req_ready[p] = rd_gnt_b[rd_bank[p]][p];
    for (int p = 0; p < NUM_WRITE_PORTS; p++)
      wr_ready[p] = wr_gnt_b[wr_bank[p]][p];
  end

  // Storage is deliberately not reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state == RF_INIT)
        mem[b][init_row] <= '0;
      else if (bank_wr_en[b])
        mem[b][bank_wr_row[b]] <= bank_wr_data[b];
      if (bank_rd_en[b])
        bank_rdata[b] <= (bank_wr_en[b] && (bank_wr_row[b] == bank_rd_row[b]))
                         ? bank_wr_data[b] : mem[b][bank_rd_row[b]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_valid <= '0;
    else     rsp_valid <= rd_req_ready;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      rsp_bank[p] <= rd_bank[p];
  end

  assign rd_rsp_valid = rsp_valid;

  always_comb begin
    rd_rsp_data = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      if (rsp_valid[p]) rd_rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[rsp_bank[p]];
  end
endmodule

// File: tb/tb_gpu_regfile_banked.sv
// Directed table-driven bench for gpu_regfile_banked with default parameters.
module tb_gpu_regfile_banked;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   rd_req_valid;
  logic [29:0]  rd_req_addr;
  logic [2:0]   rd_req_ready;
  logic [2:0]   rd_rsp_valid;
  logic [95:0]  rd_rsp_data;
  logic [4:0]   wr_valid;
  logic [49:0]  wr_addr;
  logic [159:0] wr_data;
  logic [4:0]   wr_ready;
  logic         init_done;

  int checks = 0;
  int errors = 0;

  gpu_regfile_banked dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   wv;
    logic [49:0]  wa;
    logic [159:0] wd;
    logic [2:0]   rv;
    logic [29:0]  ra;
    logic [4:0]   exp_wr;
    logic [2:0]   exp_rd;
    logic [2:0]   exp_rv;
    logic [95:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [49:0]  SWA = {10'h011, 10'h00D, 10'h009, 10'h005, 10'h001};
  localparam logic [159:0] SWD = {32'hA5A50004, 32'hA5A50003, 32'hA5A50002,
                                  32'hA5A50001, 32'hA5A50000};

  task automatic add(input logic [4:0] wv, input logic [49:0] wa, input logic [159:0] wd,
                     input logic [2:0] rv, input logic [29:0] ra, input logic [4:0] ewr,
                     input logic [2:0] erd, input logic [2:0] erv, input logic [95:0] ed);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
    v.exp_wr = ewr; v.exp_rd = erd; v.exp_rv = erv; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req_valid = '0; rd_req_addr = '0;
    wr_valid = '0; wr_addr = '0; wr_data = '0;
  endtask

  // Counts cycles spent with init_done low, starting in the first post-reset cycle.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    vec_t v;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_ready", 64'(wr_ready), 64'h0);
    check("reset rd_req_ready", 64'(rd_req_ready), 64'h0);
    check("reset rd_rsp_valid", 64'(rd_rsp_valid), 64'h0);
    check("reset rd_rsp_data", 64'(rd_rsp_data[63:0]), 64'h0);
    check("reset init_done", 64'(init_done), 64'h0);
    rst = 1'b0;

    rd_req_valid = 3'b111; wr_valid = 5'b11111;
    #3;
    check("init rd_req_ready", 64'(rd_req_ready), 64'h0);
    check("init wr_ready", 64'(wr_ready), 64'h0);
    idle_inputs();
    wait_init(n);
    check("init cycles", 64'(n), 64'd256);
    check("init_done high", 64'(init_done), 64'h1);

    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h3FF}, 5'b0, 3'b001, 3'b000, '0);
    add(5'b11111, SWA, SWD, 3'b0, '0, 5'b00001, 3'b0, 3'b001, '0);
    add(5'b11110, SWA, SWD, 3'b0, '0, 5'b00010, 3'b0, 3'b000, '0);
    add(5'b11100, SWA, SWD, 3'b0, '0, 5'b00100, 3'b0, 3'b000, '0);
    add(5'b11000, SWA, SWD, 3'b0, '0, 5'b01000, 3'b0, 3'b000, '0);
    add(5'b10000, SWA, SWD, 3'b0, '0, 5'b10000, 3'b0, 3'b000, '0);
    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h001}, 5'b0, 3'b001, 3'b000, '0);
    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h005}, 5'b0, 3'b001, 3'b001, {64'h0, 32'hA5A50000});
    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h009}, 5'b0, 3'b001, 3'b001, {64'h0, 32'hA5A50001});
    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h00D}, 5'b0, 3'b001, 3'b001, {64'h0, 32'hA5A50002});
    add(5'b0, '0, '0, 3'b001, {20'h0, 10'h011}, 5'b0, 3'b001, 3'b001, {64'h0, 32'hA5A50003});
    add(5'b00100, {20'h0, 10'h005, 20'h0}, {64'h0, 32'hDEADBEEF, 64'h0}, 3'b0, '0,
        5'b00100, 3'b0, 3'b001, {64'h0, 32'hA5A50004});
    add(5'b01001, {10'h0, 10'h002, 10'h0, 10'h0, 10'h000},
        {32'h0, 32'h0000C002, 32'h0, 32'h0, 32'h0000C000}, 3'b001, {20'h0, 10'h005},
        5'b01001, 3'b001, 3'b000, '0);
    add(5'b00010, {30'h0, 10'h004, 10'h0}, {96'h0, 32'h0000C004, 32'h0},
        3'b111, {10'h002, 10'h001, 10'h000}, 5'b00010, 3'b111, 3'b001, {64'h0, 32'hDEADBEEF});
    add(5'b10000, {10'h008, 40'h0}, {32'h0000C008, 128'h0},
        3'b111, {10'h008, 10'h004, 10'h000}, 5'b10000, 3'b010, 3'b111,
        {32'h0000C002, 32'hA5A50000, 32'h0000C000});
    add(5'b0, '0, '0, 3'b101, {10'h008, 10'h004, 10'h000}, 5'b0, 3'b100, 3'b010,
        {32'h0, 32'h0000C004, 32'h0});
    add(5'b0, '0, '0, 3'b001, {10'h008, 10'h004, 10'h000}, 5'b0, 3'b001, 3'b100,
        {32'h0000C008, 64'h0});
    add(5'b00001, {40'h0, 10'h040}, {128'h0, 32'h12345678}, 3'b010, {10'h0, 10'h040, 10'h0},
        5'b00001, 3'b010, 3'b001, {64'h0, 32'h0000C000});
    add(5'b0, '0, '0, 3'b0, '0, 5'b0, 3'b0, 3'b010, {32'h0, 32'h12345678, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd;
      rd_req_valid = v.rv; rd_req_addr = v.ra;
      #4;
      check($sformatf("v%0d wr_ready", i), 64'(wr_ready), 64'(v.exp_wr));
      check($sformatf("v%0d rd_req_ready", i), 64'(rd_req_ready), 64'(v.exp_rd));
      check($sformatf("v%0d rd_rsp_valid", i), 64'(rd_rsp_valid), 64'(v.exp_rv));
      for (int p = 0; p < 3; p++)
        if (v.exp_rv[p])
          check($sformatf("v%0d rd_rsp_data[%0d]", i, p),
                64'(rd_rsp_data[p*32 +: 32]), 64'(v.exp_data[p*32 +: 32]));
      tick();
    end
    idle_inputs();

    // Three reads in flight when reset hits: responses must be dropped.
    rd_req_valid = 3'b111; rd_req_addr = {10'h003, 10'h002, 10'h005};
    #4;
    check("pre-rst rd_req_ready", 64'(rd_req_ready), 64'h7);
    tick();
    rst = 1'b1;
    #4;
    check("pre-rst rd_rsp_valid", 64'(rd_rsp_valid), 64'h7);
    check("pre-rst rsp_data", 64'(rd_rsp_data), {32'h0000C002, 32'hDEADBEEF});
    tick();
    rst = 1'b0;
    idle_inputs();
    #3;
    check("post-rst rd_rsp_valid", 64'(rd_rsp_valid), 64'h0);
    check("post-rst init_done", 64'(init_done), 64'h0);
    wait_init(n);
    check("re-init cycles", 64'(n), 64'd256);

    rd_req_valid = 3'b001; rd_req_addr = {20'h0, 10'h005};
    #4;
    check("post-init rd_req_ready", 64'(rd_req_ready), 64'h1);
    tick();
    idle_inputs();
    #4;
    check("post-init rd_rsp_valid", 64'(rd_rsp_valid), 64'h1);
    check("post-init 0x005 cleared", 64'(rd_rsp_data[31:0]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_regfile_banked.md
Name: gpu_regfile_banked

Overview:
- Parametrised multi-ported GPU register file built from NUM_BANKS single-read/single-write banks.
- Each bank has per-bank round-robin arbitration for reads and for writes, plus valid/ready handshakes on every port.
- A self-clearing initialisation sweep runs after reset.
- Sits between operand collector (read ports) and execution-unit writeback (INT32, FP32, LSU, Tensor, SFU write ports).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_ADDR_WIDTH, 10, physical register address width; total registers = 2**REG_ADDR_WIDTH.
- NUM_BANKS, 4, power of two, ≥2; bank = addr[log2(NUM_BANKS)-1:0], row = remaining upper bits.
- NUM_READ_PORTS, 3, concurrent read requesters.
- NUM_WRITE_PORTS, 5, concurrent write requesters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_req_valid  in  NUM_READ_PORTS  per-port read request.
- rd_req_addr  in  NUM_READ_PORTS*REG_ADDR_WIDTH  per-port read address.
- rd_req_ready  out  NUM_READ_PORTS  read request accepted this cycle.
- rd_rsp_valid  out  NUM_READ_PORTS  read data valid.
- rd_rsp_data  out  NUM_READ_PORTS*DATA_WIDTH  read data.
- wr_valid  in  NUM_WRITE_PORTS  per-port write request.
- wr_addr  in  NUM_WRITE_PORTS*REG_ADDR_WIDTH  write address.
- wr_data  in  NUM_WRITE_PORTS*DATA_WIDTH  write data.
- wr_ready  out  NUM_WRITE_PORTS  write accepted this cycle.
- init_done  out  1  high once clearing sweep has finished.

Behaviour:
- Reset values: rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, wr_ready=0, init_done=0. All arbiter pointers = 0. FSM enters INIT with row counter = 0.
- Reset is synchronous; asserting rst mid-operation aborts in-flight reads (rd_rsp_valid=0 next cycle) and restarts INIT. Writes not yet accepted are discarded.
- FSM states:
  - INIT: write 0 to row counter in every bank; counter +1 per cycle. All ready outputs stay 0. After row (2**REG_ADDR_WIDTH/NUM_BANKS)-1 is written, go to RUN; init_done rises the cycle RUN is entered.
  - RUN: normal operation; stays in RUN until rst.
- Handshake: a transfer occurs when valid&&ready in the same cycle.
  - ready is combinational from the current valids and pointers.
  - Requesters must not make valid depend on ready.
  - Once asserted, valid must hold (with stable addr/data) until accepted.
- Per bank, per cycle: at most one read grant and one write grant.
  - Candidates are the ports whose address maps to that bank.
  - Winner = first requesting port at or after that bank's pointer, wrapping from the highest index to 0.
  - After a grant, the pointer moves to winner+1 (mod port count); it is unchanged if nothing is granted.
  - Read and write pointers are independent.
- Read latency 1: request accepted in cycle N gives rd_rsp_valid=1 with data in cycle N+1. rd_rsp_valid is 0 in cycles with no accept.
- Same-address read and write granted in the same cycle: write-first, so the read returns the new data.
- Reads to the same address on different ports occupy the same bank and are serialised by arbitration (no broadcast).
- Writes granted to different banks in one cycle all commit. A later read sees a write committed in any earlier cycle.
- Storage is not reset directly; its contents are defined only through the INIT sweep.

Decomposition:
- Shared package gets:
  - RF_NUM_BANKS, default 4.
  - RF_PHYS_ADDR_WIDTH, default 10.
  - typedefs rf_addr_t, rf_data_t, and enum rf_state_e {RF_INIT, RF_RUN}.
  - Existing NUM_READ_PORTS_RF / NUM_WRITE_PORTS_RF feed the port-count defaults.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], advance; outputs grant one-hot, plus registered pointer.
  - Instantiated NUM_BANKS times for reads and NUM_BANKS times for writes.
- Bank storage is an inline row array per bank, one write and one synchronous read per cycle.

Test Plan:
- Reset, then idle: init_done=0 for exactly 256 cycles (1024/4 rows), =1 from cycle 257; a read of addr 0x3FF then returns 0x00000000.
- Write port 2 writes 0xDEADBEEF to 0x005; next cycle read port 0 reads 0x005 → rd_rsp_data[0]=0xDEADBEEF exactly one cycle after accept.
- All 5 write ports target bank 1 (addrs 0x001, 0x005, 0x009, 0x00D, 0x011) and hold valid → grants on ports 0,1,2,3,4 over 5 consecutive cycles, one per cycle; all values read back correctly.
- Read ports 0–2 hit distinct banks (0x000, 0x001, 0x002) → all three ready in the same cycle. Re-issue all to bank 0 → serviced over 3 cycles in rotating order.
- Same cycle: write 0x12345678 and read at 0x040 → read returns 0x12345678.
- Assert rst while 3 reads are in flight → rd_rsp_valid=0 next cycle; init_done=0; INIT reruns and previously written 0x005 reads 0 afterwards.
